// File: rtl/dsp_pkg.sv
// Shared types and helpers for the AXI4 interconnect dispatchers.
// Holds the W-entry layout and the slave-ID range check.
package dsp_pkg;

    localparam int DSP_DATA_WIDTH = 32;
    localparam int DSP_STRB_WIDTH = DSP_DATA_WIDTH / 8;
    localparam int DSP_SLV_AMT    = 2;
    localparam int DSP_SLV_ID_W   = $clog2(DSP_SLV_AMT);

    // Packing order of one buffered W beat, MSB first.
    typedef struct packed {
        logic [DSP_SLV_ID_W-1:0]   slv_id;
        logic [DSP_DATA_WIDTH-1:0] data;
        logic [DSP_STRB_WIDTH-1:0] strb;
        logic                      last;
    } w_entry_t;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic logic illegal_slv_id(
        input int unsigned id,
        input int unsigned slv_amt
    );
        return id >= slv_amt;
    endfunction

endpackage

// File: rtl/skid_buffer_2e.sv
// Generic 2-entry full-throughput register slice (main + skid).
// in_ready_o is registered: it only reflects skid occupancy.
module skid_buffer_2e #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             out_ready_i
);

    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             pop;

    assign pop         = main_vld_q & out_ready_i;
    assign in_ready_o  = ~skid_vld_q;
    assign out_valid_o = main_vld_q;
    assign out_data_o  = main_data_q;

    always_comb begin
        main_vld_d  = main_vld_q;
        skid_vld_d  = skid_vld_q;
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (pop) begin
            if (skid_vld_q) begin
                main_data_d = skid_data_q;
                skid_vld_d  = 1'b0;
            end else begin
                main_vld_d = in_valid_i;
                if (in_valid_i) begin
                    main_data_d = in_data_i;
                end
            end
        end else if (in_valid_i) begin
            if (!main_vld_q) begin
                main_vld_d  = 1'b1;
                main_data_d = in_data_i;
            end else if (!skid_vld_q) begin
                skid_vld_d  = 1'b1;
                skid_data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_vld_q  <= 1'b0;
            skid_vld_q  <= 1'b0;
            main_data_q <= '0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            skid_vld_q  <= skid_vld_d;
            main_data_q <= main_data_d;
            skid_data_q <= skid_data_d;
        end
    end

endmodule

// File: rtl/dsp_wdata_channel.sv
// W-channel dispatcher: tags master beats with a slave ID and routes them.
// Optional burst ID lock enabled by DSP_WDATA_BURST_LOCK_EN.
module dsp_wdata_channel
    import dsp_pkg::*;
#(
    parameter int SLV_AMT    = DSP_SLV_AMT,
    parameter int DATA_WIDTH = DSP_DATA_WIDTH,
    parameter int SLV_ID_W   = $clog2(SLV_AMT)
) (
    input  logic                             ACLK_i,
    input  logic                             ARESET_i,
    input  logic [DATA_WIDTH-1:0]            m_WDATA_i,
    input  logic [DATA_WIDTH/8-1:0]          m_WSTRB_i,
    input  logic                             m_WLAST_i,
    input  logic                             m_WVALID_i,
    output logic                             m_WREADY_o,
    input  logic [SLV_ID_W-1:0]              dsp_xADDR_slv_id_i,
    input  logic                             dsp_xADDR_disable_i,
    output logic                             m_xVALID_o,
    output logic                             m_xREADY_o,
    output logic [DATA_WIDTH*SLV_AMT-1:0]    sa_WDATA_o,
    output logic [DATA_WIDTH/8*SLV_AMT-1:0]  sa_WSTRB_o,
    output logic [SLV_AMT-1:0]               sa_WLAST_o,
    output logic [SLV_AMT-1:0]               sa_WVALID_o,
    input  logic [SLV_AMT-1:0]               sa_WREADY_i
);

    localparam int STRB_W  = strb_width(DATA_WIDTH);
    localparam int ENTRY_W = SLV_ID_W + DATA_WIDTH + STRB_W + 1;

    logic                  in_ready;
    logic                  accept;
    logic [SLV_ID_W-1:0]   cur_id;
    logic                  main_vld;
    logic                  main_ready;
    logic [ENTRY_W-1:0]    main_entry;
    logic [SLV_ID_W-1:0]   main_id;
    logic [DATA_WIDTH-1:0] main_data;
    logic [STRB_W-1:0]     main_strb;
    logic                  main_last;

    assign m_WREADY_o = in_ready & ~dsp_xADDR_disable_i & ~ARESET_i;
    assign accept     = m_WVALID_i & m_WREADY_o;
    assign m_xVALID_o = m_WVALID_i;
    assign m_xREADY_o = m_WREADY_o;

`ifdef DSP_WDATA_BURST_LOCK_EN
    logic                lock_vld_q, lock_vld_d;
    logic [SLV_ID_W-1:0] lock_id_q, lock_id_d;

    always_comb begin
        lock_vld_d = lock_vld_q;
        lock_id_d  = lock_id_q;
        if (accept) begin
            if (m_WLAST_i) begin
                lock_vld_d = 1'b0;
            end else if (!lock_vld_q) begin
                lock_vld_d = 1'b1;
                lock_id_d  = dsp_xADDR_slv_id_i;
            end
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (ARESET_i) begin
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_id_q  <= lock_id_d;
        end
    end

    assign cur_id = lock_vld_q ? lock_id_q : dsp_xADDR_slv_id_i;
`else
    assign cur_id = dsp_xADDR_slv_id_i;
`endif

    skid_buffer_2e #(
        .WIDTH (ENTRY_W)
    ) u_slice (
        .clk_i       (ACLK_i),
        .rst_i       (ARESET_i),
        .in_valid_i  (accept),
        .in_ready_o  (in_ready),
        .in_data_i   ({cur_id, m_WDATA_i, m_WSTRB_i, m_WLAST_i}),
        .out_valid_o (main_vld),
        .out_data_o  (main_entry),
        .out_ready_i (main_ready)
    );

    assign {main_id, main_data, main_strb, main_last} = main_entry;

    // Beats with an out-of-range ID pop on their own so they never stall.
    always_comb begin
        main_ready  = illegal_slv_id(32'(main_id), SLV_AMT);
        sa_WVALID_o = '0;
        for (int k = 0; k < SLV_AMT; k++) begin
            if (main_vld && main_id == SLV_ID_W'(k)) begin
                sa_WVALID_o[k] = 1'b1;
                main_ready     = main_ready | sa_WREADY_i[k];
            end
        end
    end

    assign sa_WDATA_o = {SLV_AMT{main_data}};
    assign sa_WSTRB_o = {SLV_AMT{main_strb}};
    assign sa_WLAST_o = {SLV_AMT{main_last}};

endmodule
